// File: rtl/fifo_sync_core.sv
// fifo_sync_core: single-clock FIFO with a registered read port, a registered
// occupancy counter, and pointer/counter debug outputs for the FIFO checker.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky ovf/udf error flags.
//
// Request semantics: fifo_write and fifo_read are single-cycle requests
// sampled on every rising edge of clk. A write is accepted when
// fifo_write && (!fifo_full || fifo_read); a read is accepted when
// fifo_read && !fifo_empty. Rejected requests are dropped and never
// retried; the producer must watch fifo_full and the consumer fifo_empty.
// Read data appears on fifo_data_out one edge after the read is accepted.
module fifo_sync_core #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         fifo_data_in,
    input  logic                     fifo_write,
    input  logic                     fifo_read,
    output logic [WIDTH-1:0]         fifo_data_out,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   cntr
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                     ovf,
    output logic                     udf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // Accepted-request decode; a read at full frees the slot the write reuses.
    always_comb begin
        wr_en = fifo_write && (!fifo_full || fifo_read);
        rd_en = fifo_read && !fifo_empty;
    end

    // Flags come straight from the registered counter, so they move only on edges.
    always_comb begin
        fifo_full  = (cntr == FULL_CNT);
        fifo_empty = (cntr == '0);
    end

    // Storage array; deliberately not reset, writes in the reset cycle are ignored.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= fifo_data_in;
        end
    end

    // Pointers wrap by natural overflow of their AW-bit width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Registered read port; holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_data_out <= '0;
        end else if (rd_en) begin
            fifo_data_out <= mem[rd_ptr];
        end
    end

    // Occupancy counter; simultaneous accepted read and write cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cntr <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   cntr <= cntr + 1'b1;
                2'b01:   cntr <= cntr - 1'b1;
                default: cntr <= cntr;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags recording dropped requests; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (fifo_write && fifo_full && !fifo_read) ovf <= 1'b1;
            if (fifo_read && fifo_empty && !fifo_write) udf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_core.sv
// tb_fifo_sync_core: directed bench for fifo_sync_core (WIDTH=16, DEPTH=16),
// with a queue-based scoreboard tracking expected data, pointers and count.
module tb_fifo_sync_core;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] fifo_data_in;
    logic             fifo_write;
    logic             fifo_read;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       wr_ptr;
    logic [3:0]       rd_ptr;
    logic [4:0]       cntr;
`ifdef FIFO_ERR_FLAGS_EN
    logic             ovf;
    logic             udf;
`endif

    int n_tests;
    int n_fail;

    // Scoreboard state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_dout;
    logic [3:0]       exp_wr;
    logic [3:0]       exp_rd;
    int               exp_cnt;

    fifo_sync_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_data_in  (fifo_data_in),
        .fifo_write    (fifo_write),
        .fifo_read     (fifo_read),
        .fifo_data_out (fifo_data_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .wr_ptr        (wr_ptr),
        .rd_ptr        (rd_ptr),
        .cntr          (cntr)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .ovf           (ovf),
        .udf           (udf)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("dout", 32'(fifo_data_out), 32'(exp_dout));
        check("cntr", 32'(cntr), 32'(exp_cnt));
        check("wr_ptr", 32'(wr_ptr), 32'(exp_wr));
        check("rd_ptr", 32'(rd_ptr), 32'(exp_rd));
        check("full", 32'(fifo_full), 32'(exp_cnt == DEPTH));
        check("empty", 32'(fifo_empty), 32'(exp_cnt == 0));
    endtask

    // Driver: one clock of requests, then advance the model and compare.
    task automatic cycle(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        logic wa;
        logic ra;
        fifo_write   = wr;
        fifo_read    = rd;
        fifo_data_in = d;
        wa = wr && ((exp_cnt < DEPTH) || rd);
        ra = rd && (exp_cnt > 0);
        @(posedge clk);
        #1;
        if (ra) begin
            exp_dout = exp_q.pop_front();
            exp_rd   = exp_rd + 4'd1;
        end
        if (wa) begin
            exp_q.push_back(d);
            exp_wr = exp_wr + 4'd1;
        end
        exp_cnt = exp_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        fifo_write = 1'b0;
        fifo_read  = 1'b0;
        check_model();
    endtask

    // Driver: reset for n cycles with both requests held high.
    task automatic do_reset(input int n);
        rst          = 1'b1;
        fifo_write   = 1'b1;
        fifo_read    = 1'b1;
        fifo_data_in = 16'hAAAA;
        repeat (n) @(posedge clk);
        #1;
        rst        = 1'b0;
        fifo_write = 1'b0;
        fifo_read  = 1'b0;
        exp_q.delete();
        exp_dout = '0;
        exp_wr   = '0;
        exp_rd   = '0;
        exp_cnt  = 0;
        check("rst_wr_ptr", 32'(wr_ptr), 32'h0);
        check("rst_rd_ptr", 32'(rd_ptr), 32'h0);
        check("rst_cntr", 32'(cntr), 32'h0);
        check("rst_empty", 32'(fifo_empty), 32'h1);
        check("rst_full", 32'(fifo_full), 32'h0);
        check("rst_dout", 32'(fifo_data_out), 32'h0);
`ifdef FIFO_ERR_FLAGS_EN
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_udf", 32'(udf), 32'h0);
`endif
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b0;
        fifo_write   = 1'b0;
        fifo_read    = 1'b0;
        fifo_data_in = '0;

        // Reset with write held high
        do_reset(2);

        // Fill 0x0000..0x000F
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 16'(i));
        check("fill_full", 32'(fifo_full), 32'h1);
        check("fill_cntr", 32'(cntr), 32'd16);

        // Overflow: writes at full are dropped
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'hDEAD);
        check("ovf_wr_ptr", 32'(wr_ptr), 32'h0);
        check("ovf_cntr", 32'(cntr), 32'd16);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf_flag", 32'(ovf), 32'h1);
`endif

        // Drain: data appears one cycle after each read, in order, never 0xDEAD
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 16'h0);
            check("drain_dout", 32'(fifo_data_out), 32'(i));
        end
        check("drain_empty", 32'(fifo_empty), 32'h1);

        // Underflow: reads at empty are dropped, output holds
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0);
        check("udf_rd_ptr", 32'(rd_ptr), 32'h0);
        check("udf_dout", 32'(fifo_data_out), 32'h000F);
`ifdef FIFO_ERR_FLAGS_EN
        check("udf_flag", 32'(udf), 32'h1);
`endif

        // Simultaneous read+write at full
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 16'h0100 + 16'(i));
        cycle(1'b1, 1'b1, 16'hBEEF);
        check("sim_full_cntr", 32'(cntr), 32'd16);
        check("sim_full_dout", 32'(fifo_data_out), 32'h0100);
        check("sim_full_ptrs", 32'(wr_ptr == rd_ptr), 32'h1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 16'h0);
        check("sim_full_last", 32'(fifo_data_out), 32'hBEEF);

        // Simultaneous read+write at empty: no bypass
        cycle(1'b1, 1'b1, 16'h1234);
        check("sim_empty_cntr", 32'(cntr), 32'd1);
        check("sim_empty_dout", 32'(fifo_data_out), 32'hBEEF);
        cycle(1'b0, 1'b1, 16'h0);
        check("sim_empty_read", 32'(fifo_data_out), 32'h1234);

        // Stream 40 words with interleaved reads; pointers wrap twice
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, (i % 3) != 0, 16'h2000 + 16'(i));
        end
        while (exp_cnt > 0) cycle(1'b0, 1'b1, 16'h0);
        check("stream_empty", 32'(fifo_empty), 32'h1);

        // Reset mid-operation at cntr=7
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 16'h3000 + 16'(i));
        check("pre_rst_cntr", 32'(cntr), 32'd7);
        do_reset(1);

        // Still operational after reset
        cycle(1'b1, 1'b0, 16'h5A5A);
        cycle(1'b0, 1'b1, 16'h0);
        check("post_rst_dout", 32'(fifo_data_out), 32'h5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_core.md
# fifo_sync_core

Synchronous single-clock FIFO that buffers WIDTH-bit words between a producer and a consumer, with a registered read port and a registered occupancy counter. It exposes its write pointer, read pointer and counter as debug outputs so the FIFO property checker can be bound directly to it. It is the storage element the FIFO assertion suite targets, and it is the building block for later datapath buffering.

## Interface
- WIDTH, 16, data word width in bits
- DEPTH, 16, number of entries; power of two, ≥ 2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- fifo_data_in  in  WIDTH  write data
- fifo_write  in  1  write request
- fifo_read  in  1  read request
- fifo_data_out  out  WIDTH  registered read data
- fifo_full  out  1  cntr == DEPTH
- fifo_empty  out  1  cntr == 0
- wr_ptr  out  $clog2(DEPTH)  next write address
- rd_ptr  out  $clog2(DEPTH)  next read address
- cntr  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH × WIDTH register array; not reset.
- Accepted write (wr_en) = fifo_write && (!fifo_full || fifo_read).
- Accepted read (rd_en) = fifo_read && !fifo_empty.
- wr_en: mem[wr_ptr] <= fifo_data_in; wr_ptr <= wr_ptr + 1.
- rd_en: fifo_data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr + 1.
- Pointers wrap modulo DEPTH by natural overflow; no explicit compare.
- cntr: +1 on wr_en only, −1 on rd_en only, unchanged on both or neither.
- fifo_full / fifo_empty decoded combinationally from registered cntr; they change only after a clock edge.
- Boundary rules:
  - Full, write only: write dropped; wr_ptr, cntr, memory unchanged.
  - Empty, read only: read dropped; rd_ptr, cntr, fifo_data_out unchanged.
  - Full, read + write: both accepted; cntr stays DEPTH; the write lands in the slot vacated this cycle (wr_ptr == rd_ptr).
  - Empty, read + write: write accepted, read dropped; no bypass; cntr becomes 1.
  - fifo_data_out holds its last value when no read is accepted.
- Reset (any cycle, including mid-transfer): wr_ptr=0, rd_ptr=0, cntr=0, fifo_empty=1, fifo_full=0, fifo_data_out=0. Requests in the reset cycle are ignored. Memory contents are don't-care after reset.

## Timing
- Write-to-visible: word written at edge N can be read starting at edge N+1 (fifo_empty deasserts after edge N).
- Read latency: 1 cycle; data appears on fifo_data_out after the edge at which rd_en is sampled.
- Flag latency: full/empty reflect cntr after the same edge that updates it; there are no early or almost flags.
- Reset is sampled only at the rising edge of clk; outputs take reset values after the first edge with rst=1.

## Configuration
- FIFO_ERR_FLAGS_EN defined: adds outputs `ovf` (1) and `udf` (1), sticky and cleared only by rst. ovf is set the cycle after fifo_write && fifo_full && !fifo_read. udf is set the cycle after fifo_read && fifo_empty && !fifo_write. Both reset to 0.
- Undefined: ports and logic absent; dropped requests are silent.

## Test plan
- Reset: assert rst for 2 cycles with fifo_write=1 → wr_ptr=0, rd_ptr=0, cntr=0, empty=1, full=0, data_out=0.
- Fill/drain, DEPTH=16: write 0x0000..0x000F → full=1 and cntr=16 after the 16th edge; read 16 → data_out sequence 0x0000..0x000F, each one cycle after its read, then empty=1.
- Overflow: at full, write 0xDEAD with no read for 3 cycles → wr_ptr and cntr stable, and subsequent drain never returns 0xDEAD. With FIFO_ERR_FLAGS_EN, ovf=1.
- Underflow: at empty, read only for 3 cycles → rd_ptr stable, data_out holds its prior value. With FIFO_ERR_FLAGS_EN, udf=1.
- Simultaneous: at full, read + write 0xBEEF → cntr stays 16, the oldest word is output, and 0xBEEF is read out last. At empty, read + write 0x1234 → cntr=1 and the next read returns 0x1234.
- Wrap and reset mid-operation: stream 40 words with interleaved reads so the pointers wrap twice; check data order against a model; assert rst with cntr=7 → all reset values on the next edge.
